serial_frame_receiver: RTL and testbench

// - Receiving end of the 1-bit-per-clock serial link fed by the DFF delay chain.
// - Detects a start bit, shifts in WIDTH data bits LSB first, checks optional

---
 rtl/serial_frame_receiver_pkg.sv | 7 +
 rtl/serial_frame_receiver_buffer.sv | 26 ++
 rtl/serial_frame_receiver.sv | 62 ++++++
 tb/tb_serial_frame_receiver.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/serial_frame_receiver_pkg.sv
// serial_frame_receiver_pkg: FSM state encodings and bit-counter sizing shared by the receiver.
package serial_frame_receiver_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_DATA = 2'd1, ST_PARITY = 2'd2, ST_STOP = 2'd3;
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/serial_frame_receiver_buffer.sv
// frame_output_buffer: one-entry valid/ready holding register; a load while full and not draining is dropped as an overrun.
module frame_output_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             overrun
);
  logic take;
  assign take = load && (!valid || ready);
  always_ff @(posedge clk)
    if (!rst_n) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      data    <= take ? din : data;
      valid   <= take || (valid && !ready);
      overrun <= load && valid && !ready;
    end
endmodule

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: start-bit framed serial receiver with optional even parity, delivering words on a valid/ready port.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             serial_in,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic             frame_error,
  output logic             overrun
);
  localparam int CW = cnt_width(WIDTH);
  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shift;
  logic             par;
  logic             stop_edge, good;
  assign stop_edge = (state == ST_STOP);
  // even parity: data bits plus parity bit must XOR to zero
  assign good = !serial_in && !(PARITY_EN && ((^shift) ^ par));
  always_ff @(posedge CLK)
    if (!RST) begin
      state       <= ST_IDLE;
      count       <= '0;
      shift       <= '0;
      par         <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= stop_edge && !good;
      case (state)
        ST_IDLE: begin
          count <= '0;
          state <= serial_in ? ST_DATA : ST_IDLE;
        end
        ST_DATA: begin
          shift[count] <= serial_in;
          count        <= count + 1'b1;
          state        <= (count != CW'(WIDTH - 1)) ? ST_DATA : (PARITY_EN ? ST_PARITY : ST_STOP);
        end
        ST_PARITY: begin
          par   <= serial_in;
          state <= ST_STOP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  frame_output_buffer #(.WIDTH(WIDTH)) u_buf (
    .clk     (CLK),
    .rst_n   (RST),
    .load    (stop_edge && good),
    .din     (shift),
    .ready   (frame_ready),
    .data    (frame_data),
    .valid   (frame_valid),
    .overrun (overrun)
  );
endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb_serial_frame_receiver: directed frames against an 8-bit parity receiver and a 4-bit no-parity receiver.
module tb_serial_frame_receiver;
  logic       clk = 1'b0, rst = 1'b0;
  logic       s8 = 1'b0, r8 = 1'b1, v8, e8, o8;
  logic [7:0] d8;
  logic       s4 = 1'b0, r4 = 1'b1, v4, e4, o4;
  logic [3:0] d4;
  int         n_chk = 0, n_fail = 0, err8 = 0, ovr8 = 0, lat;

  always #5 clk = ~clk;

  serial_frame_receiver #(.WIDTH(8), .PARITY_EN(1'b1)) dut8 (
    .CLK(clk), .RST(rst), .serial_in(s8), .frame_data(d8), .frame_valid(v8),
    .frame_ready(r8), .frame_error(e8), .overrun(o8));
  serial_frame_receiver #(.WIDTH(4), .PARITY_EN(1'b0)) dut4 (
    .CLK(clk), .RST(rst), .serial_in(s4), .frame_data(d4), .frame_valid(v4),
    .frame_ready(r4), .frame_error(e4), .overrun(o4));

  always @(negedge clk) begin
    if (e8) err8++;
    if (o8) ovr8++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send8(input logic [7:0] d, input logic pflip, input logic stp);
    logic [10:0] f;
    f = {stp, (^d) ^ pflip, d, 1'b1};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      s8 = f[i];
    end
  endtask

  task automatic tick8(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      s8 = 1'b0;
    end
  endtask

  initial begin
    tick8(3);
    chk("rst_valid", v8, 1'b0);
    chk("rst_data", d8, 8'h00);
    chk("rst_error", e8, 1'b0);
    chk("rst_overrun", o8, 1'b0);
    rst = 1'b1;
    // partial frame cut by reset, then a clean 0x3C
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s8 = (i == 0) || (i == 2);
    end
    @(negedge clk);
    s8 = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick8(12);
    chk("partial_no_valid", v8, 1'b0);
    chk("partial_no_error", err8, 0);
    send8(8'h3C, 1'b0, 1'b0);
    tick8(1);
    chk("3c_valid", v8, 1'b1);
    chk("3c_data", d8, 8'h3C);
    tick8(1);
    chk("3c_consumed", v8, 1'b0);
    // 0xA5 with start-to-valid latency
    send8(8'hA5, 1'b0, 1'b0);
    lat = 10;
    do begin
      @(negedge clk);
      s8 = 1'b0;
      lat++;
    end while (!v8 && lat < 16);
    chk("a5_latency", lat, 11);
    chk("a5_data", d8, 8'hA5);
    tick8(1);
    chk("a5_one_cycle", v8, 1'b0);
    chk("a5_no_error", err8, 0);
    send8(8'hA5, 1'b1, 1'b0);
    tick8(1);
    chk("bad_parity_error_pulse", e8, 1'b1);
    chk("bad_parity_no_valid", v8, 1'b0);
    tick8(1);
    chk("bad_parity_pulse_len", e8, 1'b0);
    send8(8'hA5, 1'b0, 1'b1);
    tick8(2);
    chk("bad_stop_errors", err8, 2);
    chk("bad_stop_no_valid", v8, 1'b0);
    // overrun: 0x22 dropped while 0x11 is held
    r8 = 1'b0;
    send8(8'h11, 1'b0, 1'b0);
    send8(8'h22, 1'b0, 1'b0);
    tick8(1);
    chk("ovr_pulse", o8, 1'b1);
    chk("ovr_held_valid", v8, 1'b1);
    chk("ovr_held_data", d8, 8'h11);
    tick8(3);
    chk("ovr_count", ovr8, 1);
    chk("ovr_still_11", d8, 8'h11);
    r8 = 1'b1;
    tick8(1);
    chk("ovr_accept_drop", v8, 1'b0);
    tick8(4);
    chk("ovr_22_never", v8, 1'b0);
    // drain and reload on the same edge
    r8 = 1'b0;
    send8(8'h11, 1'b0, 1'b0);
    tick8(1);
    chk("swap_first_data", d8, 8'h11);
    send8(8'h22, 1'b0, 1'b0);
    r8 = 1'b1;
    tick8(1);
    chk("swap_valid_stays", v8, 1'b1);
    chk("swap_data", d8, 8'h22);
    chk("swap_no_overrun", ovr8, 1);
    tick8(1);
    chk("swap_drained", v8, 1'b0);
    chk("err_total", err8, 2);
    // 4-bit, no parity: 0xF
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      s4 = (i < 5);
    end
    lat = 5;
    do begin
      @(negedge clk);
      s4 = 1'b0;
      lat++;
    end while (!v4 && lat < 10);
    chk("w4_latency", lat, 6);
    chk("w4_data", d4, 4'hF);
    chk("w4_no_error", e4, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
